wvb_rd_arb: RTL and testbench

- Round-robin arbiter that shares one wvb_reader between N_CHANNELS waveform_buffer instances.
- Selects a channel with a pending header and locks the grant for one full waveform readout, up to the reader's wvb_rddone pulse.
- Muxes that channel's hdr/wvb data and hdr_empty to the reader, and steers the reader's rdreq/rddone strobes back to the granted buffer only.
- Sits between the per-channel waveform buffers and the single reader/DPRAM path.

---
 rtl/wvb_rd_arb.sv | 136 +++++++++++++
 tb/tb_wvb_rd_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wvb_rd_arb.sv
// Round-robin share of one wvb_reader across N_CHANNELS waveform buffers; grant held for a full readout.
// Latency: grant registered one cycle after a request is seen in IDLE; data/strobe muxing is zero-latency.
// Backpressure: reader paces via rdreq/rddone; after rddone a HOLD cycle blocks re-arbitration while hdr_empty settles.
module wvb_rd_arb #(
    parameter int N_CHANNELS   = 24,
    parameter int P_CHAN_WIDTH = 5,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [N_CHANNELS-1:0]             chan_mask,
    input  logic [N_CHANNELS-1:0]             wvb_hdr_empty,
    input  logic [N_CHANNELS*P_HDR_WIDTH-1:0] wvb_hdr_data,
    input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
    output logic [N_CHANNELS-1:0]             wvb_hdr_rdreq,
    output logic [N_CHANNELS-1:0]             wvb_rdreq,
    output logic [N_CHANNELS-1:0]             wvb_rddone,
    output logic                              rdr_hdr_empty,
    output logic [P_HDR_WIDTH-1:0]            rdr_hdr_data,
    output logic [P_DATA_WIDTH-1:0]           rdr_wvb_data,
    input  logic                              rdr_hdr_rdreq,
    input  logic                              rdr_wvb_rdreq,
    input  logic                              rdr_wvb_rddone,
    output logic                              grant_valid,
    output logic [P_CHAN_WIDTH-1:0]           grant_chan,
    output logic [15:0]                       n_served
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  state;
    logic [P_CHAN_WIDTH-1:0] ptr;
    logic [N_CHANNELS-1:0]   req;
    logic [2*N_CHANNELS-1:0] req2;
    logic [N_CHANNELS-1:0]   rot;
    logic [P_CHAN_WIDTH-1:0] pick;
    logic [P_CHAN_WIDTH-1:0] next_ptr;
    logic [15:0]             n_served_nxt;

    assign req = ~wvb_hdr_empty & chan_mask;

    // Rotate requests so bit 0 is the channel at ptr; lowest set bit is the winner.
    always_comb begin
        int off;
        int sum;
        req2 = {req, req} >> ptr;
        rot  = req2[N_CHANNELS-1:0];
        off  = 0;
        for (int j = N_CHANNELS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        sum = int'(32'(ptr)) + off;
        if (sum >= N_CHANNELS) begin
            sum = sum - N_CHANNELS;
        end
        pick = P_CHAN_WIDTH'(sum);
    end

    assign next_ptr = (grant_chan == P_CHAN_WIDTH'(N_CHANNELS - 1)) ? '0 : grant_chan + 1'b1;

    // Count only rddone seen during a grant, saturating so the counter never wraps.
    assign n_served_nxt = (state == S_GRANT && rdr_wvb_rddone && n_served != 16'hFFFF)
                          ? n_served + 16'd1 : n_served;

    // Arbitration FSM: pick in IDLE, lock until rddone, one settling cycle in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            grant_valid <= 1'b0;
            grant_chan  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && |req) begin
                        grant_chan  <= pick;
                        grant_valid <= 1'b1;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (rdr_wvb_rddone) begin
                        grant_valid <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    state <= S_IDLE;
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    // Completed-readout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_served <= '0;
        end else begin
            n_served <= n_served_nxt;
        end
    end

    // Steer the granted buffer to the reader and the reader's strobes back to it only.
    always_comb begin
        rdr_hdr_empty = 1'b1;
        rdr_hdr_data  = '0;
        rdr_wvb_data  = '0;
        wvb_hdr_rdreq = '0;
        wvb_rdreq     = '0;
        wvb_rddone    = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (state == S_GRANT && grant_chan == P_CHAN_WIDTH'(i)) begin
                rdr_hdr_empty    = wvb_hdr_empty[i];
                rdr_hdr_data     = wvb_hdr_data[i*P_HDR_WIDTH +: P_HDR_WIDTH];
                rdr_wvb_data     = wvb_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                wvb_hdr_rdreq[i] = rdr_hdr_rdreq;
                wvb_rdreq[i]     = rdr_wvb_rdreq;
                wvb_rddone[i]    = rdr_wvb_rddone;
            end
        end
    end

endmodule

// File: tb/tb_wvb_rd_arb.sv
// Bench for wvb_rd_arb: table of arbitration steps plus hand-written corner sequences.
// Expected grant channels go through a queue; each readout checks muxing, steering and the counter.
// Inputs driven on the falling edge, outputs sampled shortly after.
module tb_wvb_rd_arb;

    localparam int N  = 24;
    localparam int CW = 5;
    localparam int DW = 22;
    localparam int HW = 80;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [N-1:0]      chan_mask;
    logic [N-1:0]      wvb_hdr_empty;
    logic [N*HW-1:0]   wvb_hdr_data;
    logic [N*DW-1:0]   wvb_data;
    logic [N-1:0]      wvb_hdr_rdreq;
    logic [N-1:0]      wvb_rdreq;
    logic [N-1:0]      wvb_rddone;
    logic              rdr_hdr_empty;
    logic [HW-1:0]     rdr_hdr_data;
    logic [DW-1:0]     rdr_wvb_data;
    logic              rdr_hdr_rdreq;
    logic              rdr_wvb_rdreq;
    logic              rdr_wvb_rddone;
    logic              grant_valid;
    logic [CW-1:0]     grant_chan;
    logic [15:0]       n_served;

    wvb_rd_arb #(
        .N_CHANNELS  (N),
        .P_CHAN_WIDTH(CW),
        .P_DATA_WIDTH(DW),
        .P_HDR_WIDTH (HW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .chan_mask     (chan_mask),
        .wvb_hdr_empty (wvb_hdr_empty),
        .wvb_hdr_data  (wvb_hdr_data),
        .wvb_data      (wvb_data),
        .wvb_hdr_rdreq (wvb_hdr_rdreq),
        .wvb_rdreq     (wvb_rdreq),
        .wvb_rddone    (wvb_rddone),
        .rdr_hdr_empty (rdr_hdr_empty),
        .rdr_hdr_data  (rdr_hdr_data),
        .rdr_wvb_data  (rdr_wvb_data),
        .rdr_hdr_rdreq (rdr_hdr_rdreq),
        .rdr_wvb_rdreq (rdr_wvb_rdreq),
        .rdr_wvb_rddone(rdr_wvb_rddone),
        .grant_valid   (grant_valid),
        .grant_chan    (grant_chan),
        .n_served      (n_served)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] set_ne;
        logic [N-1:0] mask;
        int           exp_chan;
    } vec_t;

    vec_t         tbl[10];
    int           exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [N-1:0] ne;
    logic [15:0]  exp_served;
    int           n_cyc;
    bit           got;
    int           e;
    bit           bad;
    int           sat_chans[3];

    function automatic logic [HW-1:0] hdr_of(input int i);
        return {8'(i), 8'hC3, 32'hDEAD_0000 | 32'(i), 32'(i * 7919)};
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(i * 4099 + 17);
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bounded wait for grant_valid; returns number of rising edges consumed.
    task automatic wait_grant(input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            ok = grant_valid;
        end
    endtask

    // Full readout of the granted channel, ending in the HOLD cycle.
    task automatic do_readout(input int ch);
        logic [N-1:0] oh;
        oh = onehot(ch);
        #1;
        chk("grant_valid_on", 128'(grant_valid), 128'(1));
        chk("rdr_hdr_empty_grant", 128'(rdr_hdr_empty), 128'(0));
        chk("rdr_hdr_data", 128'(rdr_hdr_data), 128'(hdr_of(ch)));
        chk("rdr_wvb_data", 128'(rdr_wvb_data), 128'(data_of(ch)));
        rdr_hdr_rdreq = 1'b1;
        #1;
        chk("wvb_hdr_rdreq", 128'(wvb_hdr_rdreq), 128'(oh));
        chk("wvb_rdreq_quiet", 128'(wvb_rdreq), 128'(0));
        @(negedge clk);
        rdr_hdr_rdreq = 1'b0;
        rdr_wvb_rdreq = 1'b1;
        #1;
        chk("wvb_rdreq", 128'(wvb_rdreq), 128'(oh));
        chk("wvb_hdr_rdreq_quiet", 128'(wvb_hdr_rdreq), 128'(0));
        @(negedge clk);
        rdr_wvb_rdreq = 1'b0;
        wvb_hdr_empty = ~ne | oh;
        #1;
        chk("empty_passthru", 128'(rdr_hdr_empty), 128'(1));
        @(negedge clk);
        chk("grant_held_empty", 128'(grant_valid), 128'(1));
        wvb_hdr_empty = ~ne;
        rdr_wvb_rddone = 1'b1;
        #1;
        chk("wvb_rddone", 128'(wvb_rddone), 128'(oh));
        exp_served = (exp_served == 16'hFFFF) ? exp_served : exp_served + 16'd1;
        @(negedge clk);
        rdr_wvb_rddone = 1'b0;
        ne = ne & ~oh;
        wvb_hdr_empty = ~ne;
        #1;
        chk("hold_grant_valid", 128'(grant_valid), 128'(0));
        chk("hold_rdr_hdr_empty", 128'(rdr_hdr_empty), 128'(1));
        chk("hold_rdr_hdr_data", 128'(rdr_hdr_data), 128'(0));
        chk("hold_wvb_rddone", 128'(wvb_rddone), 128'(0));
        chk("n_served", 128'(n_served), 128'(exp_served));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{24'h800021, 24'hFFFFFF, 0};
        tbl[1] = '{24'h000000, 24'hFFFFFF, 5};
        tbl[2] = '{24'h000000, 24'hFFFFFF, 23};
        tbl[3] = '{24'h800001, 24'hFFFFFF, 0};
        tbl[4] = '{24'h000000, 24'hFFFFFF, 23};
        tbl[5] = '{24'h000200, 24'hFFFFFF, 9};
        tbl[6] = '{24'h000200, 24'hFFFFFF, 9};
        tbl[7] = '{24'h000200, 24'hFFFFFF, 9};
        tbl[8] = '{24'h000050, 24'hFFFFEF, 6};
        tbl[9] = '{24'h000000, 24'hFFFFFF, 4};

        wvb_hdr_data = '0;
        wvb_data     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            wvb_hdr_data = (wvb_hdr_data << HW) | {{(N*HW-HW){1'b0}}, hdr_of(i)};
            wvb_data     = (wvb_data << DW) | {{(N*DW-DW){1'b0}}, data_of(i)};
        end

        rst_n          = 1'b0;
        en             = 1'b1;
        chan_mask      = '1;
        ne             = '0;
        wvb_hdr_empty  = '1;
        rdr_hdr_rdreq  = 1'b0;
        rdr_wvb_rdreq  = 1'b0;
        rdr_wvb_rddone = 1'b0;
        exp_served     = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant_valid", 128'(grant_valid), 128'(0));
        chk("rst_grant_chan", 128'(grant_chan), 128'(0));
        chk("rst_n_served", 128'(n_served), 128'(0));
        chk("rst_rdr_hdr_empty", 128'(rdr_hdr_empty), 128'(1));
        chk("rst_rdr_wvb_data", 128'(rdr_wvb_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Reader strobes while idle must go nowhere and must not count.
        rdr_hdr_rdreq  = 1'b1;
        rdr_wvb_rdreq  = 1'b1;
        rdr_wvb_rddone = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_rddone_blocked", 128'(wvb_rddone), 128'(0));
            chk("idle_hdr_rdreq_blocked", 128'(wvb_hdr_rdreq), 128'(0));
        end
        rdr_hdr_rdreq  = 1'b0;
        rdr_wvb_rdreq  = 1'b0;
        rdr_wvb_rddone = 1'b0;
        @(negedge clk);
        chk("idle_rddone_no_count", 128'(n_served), 128'(0));

        // Table-driven arbitration order, wrap and single-requester fairness.
        for (int i = 0; i < 10; i++) begin
            ne            = ne | tbl[i].set_ne;
            wvb_hdr_empty = ~ne;
            chan_mask     = tbl[i].mask;
            exp_q.push_back(tbl[i].exp_chan);
            wait_grant(20, n_cyc, got);
            e = exp_q.pop_front();
            if (!got) begin
                chk("grant_timeout", 128'(0), 128'(1));
            end else begin
                chk("grant_chan", 128'(grant_chan), 128'(e));
                if (i > 0) chk("grant_gap", 128'(n_cyc + 1), 128'(3));
                do_readout(e);
            end
        end

        // Masked-off requester is never served until its mask bit returns.
        ne            = onehot(5);
        wvb_hdr_empty = ~ne;
        chan_mask     = 24'hFFFFDF;
        bad           = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (grant_valid || !rdr_hdr_empty) bad = 1'b1;
        end
        chk("masked_no_grant", 128'(bad), 128'(0));
        chan_mask = '1;
        exp_q.push_back(5);
        wait_grant(1, n_cyc, got);
        e = exp_q.pop_front();
        chk("unmask_grant_1cyc", 128'(got), 128'(1));
        if (got) begin
            chk("unmask_grant_chan", 128'(grant_chan), 128'(e));
            do_readout(e);
        end

        // Dropping en mid-readout lets the readout finish but blocks new grants.
        ne            = onehot(3);
        wvb_hdr_empty = ~ne;
        exp_q.push_back(3);
        wait_grant(20, n_cyc, got);
        e = exp_q.pop_front();
        chk("en_grant_seen", 128'(got), 128'(1));
        if (got) begin
            chk("en_grant_chan", 128'(grant_chan), 128'(e));
            en = 1'b0;
            do_readout(e);
        end
        ne            = ne | onehot(7);
        wvb_hdr_empty = ~ne;
        bad           = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (grant_valid) bad = 1'b1;
        end
        chk("en_low_no_grant", 128'(bad), 128'(0));
        en = 1'b1;
        exp_q.push_back(7);
        wait_grant(5, n_cyc, got);
        e = exp_q.pop_front();
        chk("en_high_grant_seen", 128'(got), 128'(1));
        if (got) begin
            chk("en_high_grant_chan", 128'(grant_chan), 128'(e));
            do_readout(e);
        end

        // Reset in the middle of a grant; arbitration restarts from channel 0.
        ne            = onehot(10);
        wvb_hdr_empty = ~ne;
        exp_q.push_back(10);
        wait_grant(20, n_cyc, got);
        e = exp_q.pop_front();
        chk("pre_rst_grant_chan", 128'(grant_chan), 128'(e));
        ne             = ne | onehot(2) | onehot(20);
        wvb_hdr_empty  = ~ne;
        rdr_hdr_rdreq  = 1'b1;
        rdr_wvb_rdreq  = 1'b1;
        rdr_wvb_rddone = 1'b1;
        rst_n          = 1'b0;
        #1;
        chk("arst_grant_valid", 128'(grant_valid), 128'(0));
        chk("arst_grant_chan", 128'(grant_chan), 128'(0));
        chk("arst_n_served", 128'(n_served), 128'(0));
        chk("arst_rdr_hdr_empty", 128'(rdr_hdr_empty), 128'(1));
        chk("arst_rdr_hdr_data", 128'(rdr_hdr_data), 128'(0));
        chk("arst_strobes", 128'({wvb_hdr_rdreq, wvb_rdreq, wvb_rddone}), 128'(0));
        exp_served     = '0;
        rdr_hdr_rdreq  = 1'b0;
        rdr_wvb_rdreq  = 1'b0;
        rdr_wvb_rddone = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(2);
        wait_grant(20, n_cyc, got);
        e = exp_q.pop_front();
        chk("post_rst_grant_chan", 128'(grant_chan), 128'(e));
        if (got) do_readout(e);

        // Counter saturation from a preloaded value near the top.
        force dut.n_served = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.n_served;
        exp_served = 16'hFFFE;
        #1;
        chk("preload_n_served", 128'(n_served), 128'(16'hFFFE));
        ne            = ne | onehot(11);
        wvb_hdr_empty = ~ne;
        sat_chans[0]  = 10;
        sat_chans[1]  = 11;
        sat_chans[2]  = 20;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(sat_chans[k]);
            wait_grant(20, n_cyc, got);
            e = exp_q.pop_front();
            if (!got) begin
                chk("sat_grant_timeout", 128'(0), 128'(1));
            end else begin
                chk("sat_grant_chan", 128'(grant_chan), 128'(e));
                do_readout(e);
            end
        end
        chk("n_served_saturated", 128'(n_served), 128'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
